muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the integer multiply (`imul`) and divide (`divi`) operations of the multicycle MIPS core. The main control FSM drives ALU control code 15 (imul) or 16 (divi) with a `start` pulse. This block then runs a WIDTH-iteration shift-add multiply or restoring divide, holds `busy` so the main FSM stalls, and pulses `done` when the HI/LO results are valid. All other ALU operations bypass this block.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and ALU encodings for the multiply/divide sequencer.
// ALU_IMUL/ALU_DIVI must track the ALU control unit's code assignment.
package muldiv_pkg;

   localparam logic [4:0] ALU_IMUL = 5'd15;
   localparam logic [4:0] ALU_DIVI = 5'd16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide; purely combinational.
// Latency: 0 cycles. Backpressure: none, the sequencer decides when to register the result.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  op_t              op,
   input  logic [WIDTH:0]   acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH:0]   nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] divisor;

   always_comb begin
      divisor = {1'b0, opb};
      sum     = acc_hi + (acc_lo[0] ? divisor : '0);
      shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
      nxt_hi  = '0;
      nxt_lo  = '0;
      if (op == OP_MUL) begin
         // The add carry shifts into the top of the accumulator.
         nxt_hi = {1'b0, sum[WIDTH:1]};
         nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end else if (shifted >= divisor) begin
         nxt_hi = shifted - divisor;
         nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
         nxt_hi = shifted;
         nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative imul/divi unit for the multicycle core; MULDIV_SIGNED_EN selects two's-complement.
// Latency: WIDTH+1 cycles from accept to done (1 cycle for divide by zero).
// Backpressure: busy stalls the main FSM; start outside IDLE is dropped, never queued.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [4:0]       alu_cnt,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   op_t              op;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opb;
   logic [WIDTH:0]   step_hi;
   logic [WIDTH-1:0] step_lo;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic             is_op, accept, dz_accept;

   assign is_op     = (alu_cnt == ALU_IMUL) || (alu_cnt == ALU_DIVI);
   assign accept    = (state == IDLE) && start && is_op;
   assign dz_accept = accept && (alu_cnt == ALU_DIVI) && (op_b == '0);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op     (op),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo),
      .opb    (opb),
      .nxt_hi (step_hi),
      .nxt_lo (step_lo)
   );

`ifdef MULDIV_SIGNED_EN
   logic sign_a, sign_b;

   assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
   assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sign_a <= 1'b0;
         sign_b <= 1'b0;
      end else if (accept) begin
         sign_a <= op_a[WIDTH-1];
         sign_b <= op_b[WIDTH-1];
      end
   end

   // Truncating division: quotient sign from both operands, remainder follows the dividend.
   always_comb begin
      res_hi = step_hi[WIDTH-1:0];
      res_lo = step_lo;
      if (op == OP_MUL) begin
         if (sign_a ^ sign_b)
            {res_hi, res_lo} = -{step_hi[WIDTH-1:0], step_lo};
      end else begin
         if (sign_a ^ sign_b)
            res_lo = -step_lo;
         if (sign_a)
            res_hi = -step_hi[WIDTH-1:0];
      end
   end
`else
   assign mag_a  = op_a;
   assign mag_b  = op_b;
   assign res_hi = step_hi[WIDTH-1:0];
   assign res_lo = step_lo;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (dz_accept)
               state_nxt = DONE;
            else if (accept)
               state_nxt = RUN;
         end
         RUN: begin
            if (cnt == LAST)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Operands load as multiplier/dividend in acc_lo, multiplicand/divisor in opb.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op          <= OP_MUL;
         cnt         <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         opb         <= '0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         op          <= (alu_cnt == ALU_DIVI) ? OP_DIV : OP_MUL;
         cnt         <= '0;
         acc_hi      <= '0;
         acc_lo      <= mag_a;
         opb         <= mag_b;
         div_by_zero <= 1'b0;
         if (dz_accept) begin
            hi          <= op_a;
            lo          <= '1;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         acc_hi <= step_hi;
         acc_lo <= step_lo;
         cnt    <= cnt + 1'b1;
         if (cnt == LAST) begin
            hi <= res_hi;
            lo <= res_lo;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an arithmetic reference model.
// The model follows MULDIV_SIGNED_EN the same way the design build does.
module tb_muldiv_sequencer;

   localparam int W = 32;
   localparam logic [4:0] C_MUL = 5'd15;
   localparam logic [4:0] C_DIV = 5'd16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [4:0]    alu_cnt;
   logic [W-1:0]  op_a, op_b;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [W-1:0]  prev_hi, prev_lo;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .alu_cnt     (alu_cnt),
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input logic [4:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
      logic [63:0] p;
      int          as, bs;
      longint      ps;
      as = a;
      bs = b;
      ed = 1'b0;
      if (code == C_DIV && b == 0) begin
         eh = a;
         el = '1;
         ed = 1'b1;
      end else if (code == C_MUL) begin
`ifdef MULDIV_SIGNED_EN
         ps = longint'(as) * longint'(bs);
         p  = ps;
`else
         p = {32'b0, a} * {32'b0, b};
`endif
         eh = p[63:32];
         el = p[31:0];
      end else begin
`ifdef MULDIV_SIGNED_EN
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            el = 32'h8000_0000;
            eh = 32'h0;
         end else begin
            el = as / bs;
            eh = as % bs;
         end
`else
         el = a / b;
         eh = a % b;
`endif
      end
   endtask

   // Follows an operation whose start is already driven, up to the first idle cycle after done.
   task automatic run_checks(input logic [4:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int poke);
      logic [W-1:0] eh, el;
      logic         ed;
      int           lat;
      model(code, a, b, eh, el, ed);
      lat = ed ? 1 : W + 1;
      @(posedge clk);
      #1 start = 1'b0;
      op_a = $urandom;
      op_b = $urandom;
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         check("busy", busy, 64'(k <= lat));
         check("done", done, 64'(k == lat));
         if (k < lat) begin
            check("hi_hold", hi, prev_hi);
            check("lo_hold", lo, prev_lo);
            check("dbz_clear", div_by_zero, 0);
         end else begin
            check("hi", hi, eh);
            check("lo", lo, el);
            check("dbz", div_by_zero, ed);
         end
         start = (k == poke);
         if (k == poke) begin
            alu_cnt = ($urandom_range(0, 1) != 0) ? C_MUL : C_DIV;
            op_a    = $urandom;
            op_b    = $urandom;
         end
      end
      start   = 1'b0;
      prev_hi = eh;
      prev_lo = el;
   endtask

   task automatic do_op(input logic [4:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke);
      @(negedge clk);
      start   = 1'b1;
      alu_cnt = code;
      op_a    = a;
      op_b    = b;
      run_checks(code, a, b, poke);
   endtask

   initial begin
      logic [4:0]   code;
      logic [W-1:0] a, b;
      rst_n   = 1'b0;
      start   = 1'b0;
      alu_cnt = 5'd0;
      op_a    = '0;
      op_b    = '0;
      prev_hi = '0;
      prev_lo = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_dbz", div_by_zero, 0);
      rst_n = 1'b1;

      do_op(C_MUL, 32'd7, 32'd6, 0);
      do_op(C_DIV, 32'd100, 32'd7, 5);
      do_op(C_DIV, 32'd5, 32'd0, 1);
      do_op(C_MUL, 32'hFFFF_FFF9, 32'd3, W + 1);
      do_op(C_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

      // Non-muldiv ALU codes must not start the sequencer.
      @(negedge clk);
      start   = 1'b1;
      alu_cnt = 5'd3;
      repeat (3) begin
         @(negedge clk);
         check("ign_busy", busy, 0);
         check("ign_lo", lo, prev_lo);
      end
      start = 1'b0;

      // Reset in the middle of an imul, then a fresh accept right after release.
      @(negedge clk);
      start   = 1'b1;
      alu_cnt = C_MUL;
      op_a    = 32'd1234;
      op_b    = 32'd5678;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_hi", hi, 0);
      check("mid_rst_lo", lo, 0);
      prev_hi = '0;
      prev_lo = '0;
      rst_n   = 1'b1;
      start   = 1'b1;
      alu_cnt = C_MUL;
      op_a    = 32'd9;
      op_b    = 32'd11;
      run_checks(C_MUL, 32'd9, 32'd11, 0);

      for (int i = 0; i < 24; i++) begin
         code = ($urandom_range(0, 1) != 0) ? C_MUL : C_DIV;
         a    = $urandom;
         b    = $urandom;
         case ($urandom_range(0, 4))
            0: b = '0;
            1: b = $urandom_range(1, 15);
            2: a = $urandom_range(0, 1000);
            3: b = -$urandom_range(1, 9);
            default: ;
         endcase
         do_op(code, a, b, $urandom_range(0, W + 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
